// File: rtl/pulse_readback.sv
// -----------------------------------------------------------------------------
// pulse_readback
//
// Transmit-side companion to the pulse_control command receiver. On a request
// it snapshots the active pulse parameter set and sends it to the host as a
// fixed 15-byte 8N1 UART frame. Host software uses the frame to confirm what
// the pulse generator is actually running.
//
// Frame layout (byte 0 first, each byte LSB first):
//   HDR_BYTE, per[31:24], per[23:16], per[15:8], per[7:0],
//   p1wid[15:8], p1wid[7:0], del[15:8], del[7:0], p2wid[15:8], p2wid[7:0],
//   cp, {1'b0,pr_att}, {1'b0,po_att}, CHK
//   CHK is the XOR of the 13 payload bytes (the header is not included).
//
// Ports:
//   clk       in   clk_uart domain clock, rising edge
//   resetn    in   asynchronous active-low reset
//   req       in   readback request, level-sampled while idle
//   per       in   [31:0] pulse period
//   p1wid     in   [15:0] pulse 1 width
//   del       in   [15:0] pulse 1 -> pulse 2 delay
//   p2wid     in   [15:0] pulse 2 width
//   cp        in   [7:0]  CPMG count
//   pr_att    in   [6:0]  pre-attenuator value
//   po_att    in   [6:0]  post-attenuator value
//   RS232_Tx  out  UART serial output, idle high, driven from a flop
//   busy      out  high while a frame is in progress
//   done      out  one-cycle pulse when the final stop bit completes
// -----------------------------------------------------------------------------
module pulse_readback #(
  parameter int          CLKS_PER_BIT = 104,
  parameter logic [7:0]  HDR_BYTE     = 8'hA5
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic [31:0] per,
  input  logic [15:0] p1wid,
  input  logic [15:0] del,
  input  logic [15:0] p2wid,
  input  logic [7:0]  cp,
  input  logic [6:0]  pr_att,
  input  logic [6:0]  po_att,
  output logic        RS232_Tx,
  output logic        busy,
  output logic        done
);

  localparam int             TW        = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0]  TMAX      = TW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]     LAST_BYTE = 4'd14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state;
  logic [TW-1:0]   timer;
  logic [2:0]      bit_idx;
  logic [2:0]      next_bit;
  logic [3:0]      byte_idx;
  logic            tick;
  logic            accept;
  logic [7:0]      cur_byte;

  // Snapshot of the parameter set, captured on the accepting edge
  logic [31:0]     per_s;
  logic [15:0]     p1wid_s;
  logic [15:0]     del_s;
  logic [15:0]     p2wid_s;
  logic [7:0]      cp_s;
  logic [6:0]      pr_att_s;
  logic [6:0]      po_att_s;
  logic [7:0]      chk_s;

  // Checksum over the 13 payload bytes, computed from the live inputs so it
  // can be captured on the same edge as the rest of the snapshot.
  function automatic logic [7:0] payload_xor(
    input logic [31:0] f_per,
    input logic [15:0] f_p1wid,
    input logic [15:0] f_del,
    input logic [15:0] f_p2wid,
    input logic [7:0]  f_cp,
    input logic [6:0]  f_pr_att,
    input logic [6:0]  f_po_att
  );
    logic [7:0] x;
    x = f_per[31:24] ^ f_per[23:16] ^ f_per[15:8] ^ f_per[7:0];
    x = x ^ f_p1wid[15:8] ^ f_p1wid[7:0];
    x = x ^ f_del[15:8]   ^ f_del[7:0];
    x = x ^ f_p2wid[15:8] ^ f_p2wid[7:0];
    x = x ^ f_cp ^ {1'b0, f_pr_att} ^ {1'b0, f_po_att};
    return x;
  endfunction

  assign accept   = (state == IDLE) && req;
  assign tick     = (timer == TMAX);
  assign next_bit = bit_idx + 3'd1;

  // Byte selected for transmission by the current byte index
  always_comb begin
    cur_byte = HDR_BYTE;
    case (byte_idx)
      4'd0:    cur_byte = HDR_BYTE;
      4'd1:    cur_byte = per_s[31:24];
      4'd2:    cur_byte = per_s[23:16];
      4'd3:    cur_byte = per_s[15:8];
      4'd4:    cur_byte = per_s[7:0];
      4'd5:    cur_byte = p1wid_s[15:8];
      4'd6:    cur_byte = p1wid_s[7:0];
      4'd7:    cur_byte = del_s[15:8];
      4'd8:    cur_byte = del_s[7:0];
      4'd9:    cur_byte = p2wid_s[15:8];
      4'd10:   cur_byte = p2wid_s[7:0];
      4'd11:   cur_byte = cp_s;
      4'd12:   cur_byte = {1'b0, pr_att_s};
      4'd13:   cur_byte = {1'b0, po_att_s};
      4'd14:   cur_byte = chk_s;
      default: cur_byte = HDR_BYTE;
    endcase
  end

  // Snapshot registers: pure data, no reset needed; only loaded on accept
  always_ff @(posedge clk) begin
    if (accept) begin
      per_s    <= per;
      p1wid_s  <= p1wid;
      del_s    <= del;
      p2wid_s  <= p2wid;
      cp_s     <= cp;
      pr_att_s <= pr_att;
      po_att_s <= po_att;
      chk_s    <= payload_xor(per, p1wid, del, p2wid, cp, pr_att, po_att);
    end
  end

  // Transmit FSM. RS232_Tx is loaded with the value of the *next* bit on the
  // edge that ends the current one, so every bit is held for exactly
  // CLKS_PER_BIT cycles and bytes follow each other with no gap.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      RS232_Tx <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      byte_idx <= 4'd0;
      bit_idx  <= 3'd0;
      timer    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          RS232_Tx <= 1'b1;
          timer    <= '0;
          if (req) begin
            busy     <= 1'b1;
            byte_idx <= 4'd0;
            bit_idx  <= 3'd0;
            RS232_Tx <= 1'b0;
            state    <= START;
          end
        end

        START: begin
          if (tick) begin
            timer    <= '0;
            bit_idx  <= 3'd0;
            RS232_Tx <= cur_byte[0];
            state    <= DATA;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        DATA: begin
          if (tick) begin
            timer <= '0;
            if (bit_idx == 3'd7) begin
              RS232_Tx <= 1'b1;
              state    <= STOP;
            end else begin
              bit_idx  <= next_bit;
              RS232_Tx <= cur_byte[next_bit];
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        STOP: begin
          if (tick) begin
            timer <= '0;
            if (byte_idx != LAST_BYTE) begin
              byte_idx <= byte_idx + 4'd1;
              RS232_Tx <= 1'b0;
              state    <= START;
            end else begin
              // Last stop bit finished; a req still high now is only seen
              // on the next edge, once the FSM is back in IDLE.
              RS232_Tx <= 1'b1;
              done     <= 1'b1;
              busy     <= 1'b0;
              state    <= IDLE;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        default: begin
          RS232_Tx <= 1'b1;
          busy     <= 1'b0;
          timer    <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
